coin_acceptor: RTL

//  Front end of the candy vending path. Takes three raw, bouncy coin-sensor levels
//  (nickel, dime, quarter), synchronises and debounces them, and turns each coin

---
 rtl/coin_acceptor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and debounces three coin sensors and serialises each coin into one pulse.
// Optional macro COIN_AUDIT_EN adds saturating pulse/reject audit counters.
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       n_raw,
   input  logic       d_raw,
   input  logic       q_raw,
   input  logic       accept_en,
   output logic       n,
   output logic       d,
   output logic       q,
   output logic       reject,
   output logic [1:0] reject_type,
`ifdef COIN_AUDIT_EN
   output logic       busy,
   output logic [7:0] n_cnt,
   output logic [7:0] d_cnt,
   output logic [7:0] q_cnt,
   output logic [7:0] rej_cnt
`else
   output logic       busy
`endif
);

   localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [DCW-1:0] DB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, GAP = 2'd2} state_t;

   // Bit order everywhere is {quarter, dime, nickel}, so the highest set bit wins.
   function automatic logic [2:0] pick_hi(input logic [2:0] v);
      logic [2:0] r;
      r = 3'b000;
      if (v[2])      r = 3'b100;
      else if (v[1]) r = 3'b010;
      else if (v[0]) r = 3'b001;
      else           r = 3'b000;
      return r;
   endfunction

   function automatic logic [1:0] type_code(input logic [2:0] oh);
      logic [1:0] r;
      case (oh)
         3'b001:  r = 2'b01;
         3'b010:  r = 2'b10;
         3'b100:  r = 2'b11;
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   logic [2:0]     raw_s;
   logic [2:0]     sync1_r, sync2_r, filt_r, rise_r;
   logic [DCW-1:0] db_cnt_r [3];
   logic [2:0]     pend_r, rej_pend_r;
   state_t         state_r;
   logic [GCW-1:0] gap_cnt_r;
   logic           free_s;
   logic [2:0]     take_s, pend_keep_s, acc_s, rej_all_s, rej_sel_s, pend_nxt_s;

   assign raw_s = {q_raw, d_raw, n_raw};

   // Synchroniser and per-channel debounce filter with rising-edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
         filt_r  <= 3'b000;
         rise_r  <= 3'b000;
         for (int i = 0; i < 3; i++) db_cnt_r[i] <= DCW'(0);
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         for (int i = 0; i < 3; i++) begin
            if (sync2_r[i] != filt_r[i]) begin
               if (db_cnt_r[i] == DB_LAST) begin
                  filt_r[i]   <= sync2_r[i];
                  db_cnt_r[i] <= DCW'(0);
                  rise_r[i]   <= sync2_r[i];
               end else begin
                  db_cnt_r[i] <= db_cnt_r[i] + DCW'(1);
                  rise_r[i]   <= 1'b0;
               end
            end else begin
               db_cnt_r[i] <= DCW'(0);
               rise_r[i]   <= 1'b0;
            end
         end
      end
   end

   // Dispatch and admission: a bit being emitted this edge frees its slot for a new event
   always_comb begin
      free_s = 1'b0;
      case (state_r)
         IDLE:    free_s = 1'b1;
         EMIT:    free_s = (GAP_CYCLES == 0);
         GAP:     free_s = (gap_cnt_r == GAP_LAST);
         default: free_s = 1'b1;
      endcase
      if (free_s) take_s = pick_hi(pend_r);
      else        take_s = 3'b000;
      pend_keep_s = pend_r & ~take_s;
      acc_s       = rise_r & ~pend_keep_s & {3{accept_en}};
      rej_all_s   = rej_pend_r | (rise_r & ~acc_s);
      rej_sel_s   = pick_hi(rej_all_s);
      pend_nxt_s  = pend_keep_s | acc_s;
   end

   // Pending coin bits and one-per-cycle reject reporting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_r      <= 3'b000;
         rej_pend_r  <= 3'b000;
         reject      <= 1'b0;
         reject_type <= 2'b00;
      end else begin
         pend_r      <= pend_nxt_s;
         rej_pend_r  <= rej_all_s & ~rej_sel_s;
         reject      <= |rej_all_s;
         reject_type <= type_code(rej_sel_s);
      end
   end

   // Emit FSM; when the gap expires with work pending it re-enters EMIT without an extra idle cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         gap_cnt_r <= GCW'(0);
         {q, d, n} <= 3'b000;
         busy      <= 1'b0;
      end else begin
         case (state_r)
            IDLE, GAP: begin
               if (state_r == GAP && gap_cnt_r != GAP_LAST) begin
                  gap_cnt_r <= gap_cnt_r + GCW'(1);
                  {q, d, n} <= 3'b000;
                  busy      <= 1'b1;
               end else if (|take_s) begin
                  state_r   <= EMIT;
                  {q, d, n} <= take_s;
                  busy      <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  {q, d, n} <= 3'b000;
                  busy      <= |pend_nxt_s;
               end
            end
            EMIT: begin
               if (GAP_CYCLES > 0) begin
                  state_r   <= GAP;
                  gap_cnt_r <= GCW'(0);
                  {q, d, n} <= 3'b000;
                  busy      <= 1'b1;
               end else if (|take_s) begin
                  state_r   <= EMIT;
                  {q, d, n} <= take_s;
                  busy      <= 1'b1;
               end else begin
                  state_r   <= IDLE;
                  {q, d, n} <= 3'b000;
                  busy      <= |pend_nxt_s;
               end
            end
            default: begin
               state_r   <= IDLE;
               {q, d, n} <= 3'b000;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef COIN_AUDIT_EN
   // Saturating audit counters of emitted pulses and rejects
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_cnt   <= 8'd0;
         d_cnt   <= 8'd0;
         q_cnt   <= 8'd0;
         rej_cnt <= 8'd0;
      end else begin
         if (n && n_cnt != 8'hFF)        n_cnt   <= n_cnt + 8'd1;
         if (d && d_cnt != 8'hFF)        d_cnt   <= d_cnt + 8'd1;
         if (q && q_cnt != 8'hFF)        q_cnt   <= q_cnt + 8'd1;
         if (reject && rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
      end
   end
`endif

endmodule
